// File: rtl/seq_pkg.sv
// Shared definitions for the "001" sequence detector and its serial front end.
// Holds the FSM state type, the idle line level and the default word width.
package seq_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } seq_state_t;

    // A steady 1 on the detector input keeps it parked in its initial state.
    localparam logic IDLE_LEVEL = 1'b1;

    localparam int unsigned DEFAULT_WIDTH = 32'd8;

endpackage

// File: rtl/seq_bit_counter.sv
// Loadable down-counter over WIDTH bit positions with enable and a
// terminal-count flag raised when the count sits at zero.
module seq_bit_counter
    import seq_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic [$clog2(WIDTH)-1:0] load_value,
    input  logic                     en,
    output logic [$clog2(WIDTH)-1:0] count,
    output logic                     terminal
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] ONE = CW'(1);

    assign terminal = (count == '0);

    // Load wins over enable; the count never wraps below zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en && !terminal) begin
            count <= count - ONE;
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/seq_bit_serializer.sv
// Parallel-in, serial-out feeder for the "001" detector: words arrive over a
// valid/ready handshake and leave one bit per enabled cycle on bit_out.
module seq_bit_serializer
    import seq_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter bit          MSB_FIRST = 1'b1,
    parameter logic        IDLE_BIT  = IDLE_LEVEL
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             word_done
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_INDEX = CW'(WIDTH - 32'd1);

    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    seq_state_t       state_r;
    logic [WIDTH-1:0] shift_r;
    logic [WIDTH-1:0] next_shift_s;
    logic [CW-1:0]    count_s;
    logic             last_s;
    logic             last_step_s;
    logic             accept_s;
    logic             count_en_s;

    assign next_shift_s = advance(shift_r);
    assign last_step_s  = (state_r == ST_SHIFT) && shift_en && last_s;
    assign load_ready   = (state_r == ST_IDLE) || last_step_s;
    assign accept_s     = load_valid && load_ready;
    assign count_en_s   = (state_r == ST_SHIFT) && shift_en && (count_s != '0);

    seq_bit_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (accept_s),
        .load_value (LAST_INDEX),
        .en         (count_en_s),
        .count      (count_s),
        .terminal   (last_s)
    );

    // FSM, shift register and registered serial outputs. bit_out is loaded
    // with the next head bit so it always mirrors the register's head.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            shift_r   <= '0;
            bit_out   <= IDLE_BIT;
            bit_valid <= 1'b0;
            busy      <= 1'b0;
            word_done <= 1'b0;
        end else begin
            word_done <= last_step_s;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_r   <= ST_SHIFT;
                        shift_r   <= load_data;
                        bit_out   <= head_bit(load_data);
                        bit_valid <= 1'b1;
                        busy      <= 1'b1;
                    end else begin
                        state_r   <= ST_IDLE;
                        bit_out   <= IDLE_BIT;
                        bit_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (accept_s) begin
                        // Reload on the last-bit cycle keeps the stream gapless.
                        state_r   <= ST_SHIFT;
                        shift_r   <= load_data;
                        bit_out   <= head_bit(load_data);
                        bit_valid <= 1'b1;
                        busy      <= 1'b1;
                    end else if (last_step_s) begin
                        state_r   <= ST_IDLE;
                        bit_out   <= IDLE_BIT;
                        bit_valid <= 1'b0;
                        busy      <= 1'b0;
                    end else if (shift_en) begin
                        shift_r   <= next_shift_s;
                        bit_out   <= head_bit(next_shift_s);
                    end else begin
                        shift_r   <= shift_r;
                        bit_out   <= bit_out;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    bit_out   <= IDLE_BIT;
                    bit_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Directed bench for seq_bit_serializer: an MSB-first instance for most
// scenarios plus an LSB-first instance for bit ordering.
module tb_seq_bit_serializer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load_valid = 1'b0;
    logic [7:0] load_data = 8'h00;
    logic       shift_en = 1'b1;
    logic       load_ready, bit_out, bit_valid, busy, word_done;

    logic       lsb_load_valid = 1'b0;
    logic [7:0] lsb_load_data = 8'h00;
    logic       lsb_shift_en = 1'b1;
    logic       lsb_load_ready, lsb_bit_out, lsb_bit_valid, lsb_busy, lsb_word_done;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) u_msb (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .shift_en(shift_en), .bit_out(bit_out),
        .bit_valid(bit_valid), .busy(busy), .word_done(word_done)
    );

    seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_lsb (
        .clk(clk), .reset(reset), .load_valid(lsb_load_valid), .load_ready(lsb_load_ready),
        .load_data(lsb_load_data), .shift_en(lsb_shift_en), .bit_out(lsb_bit_out),
        .bit_valid(lsb_bit_valid), .busy(lsb_busy), .word_done(lsb_word_done)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) cyc();
        checks++;
        if ({bit_out, bit_valid, busy, word_done} !== 4'b1000) begin
            failures++;
            $display("FAIL reset_hold {bit,valid,busy,done} got=%b exp=1000", {bit_out, bit_valid, busy, word_done});
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({bit_out, bit_valid, busy, word_done, load_ready} !== 5'b10001) begin
                failures++;
                $display("FAIL idle_after_reset[%0d] {bit,valid,busy,done,ready} got=%b exp=10001", i, {bit_out, bit_valid, busy, word_done, load_ready});
            end
            checks++;
            if ({lsb_bit_out, lsb_bit_valid, lsb_busy, lsb_word_done, lsb_load_ready} !== 5'b10001) begin
                failures++;
                $display("FAIL lsb_idle_after_reset[%0d] got=%b exp=10001", i, {lsb_bit_out, lsb_bit_valid, lsb_busy, lsb_word_done, lsb_load_ready});
            end
            cyc();
        end
    endtask

    task automatic test_single_word();
        logic [7:0] w;
        w = 8'h24;
        shift_en = 1'b1;
        load_valid = 1'b1;
        load_data = w;
        cyc();
        load_valid = 1'b0;
        load_data = 8'hFF;
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if ({bit_out, bit_valid, busy, word_done} !== {w[8-c], 3'b110}) begin
                failures++;
                $display("FAIL single_word cycle %0d got=%b exp=%b", c, {bit_out, bit_valid, busy, word_done}, {w[8-c], 3'b110});
            end
            checks++;
            if (load_ready !== (c == 8)) begin
                failures++;
                $display("FAIL single_ready cycle %0d got=%b exp=%b", c, load_ready, (c == 8));
            end
            cyc();
        end
        checks++;
        if ({bit_out, bit_valid, busy, word_done} !== 4'b1001) begin
            failures++;
            $display("FAIL single_done got=%b exp=1001", {bit_out, bit_valid, busy, word_done});
        end
        cyc();
        checks++;
        if ({bit_out, bit_valid, word_done} !== 3'b100) begin
            failures++;
            $display("FAIL single_after_done got=%b exp=100", {bit_out, bit_valid, word_done});
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] w2;
        logic       eb;
        w2 = 8'h01;
        load_valid = 1'b1;
        load_data = 8'hFF;
        cyc();
        load_valid = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            eb = (c <= 8) ? 1'b1 : w2[16-c];
            checks++;
            if ({bit_out, bit_valid, busy, word_done} !== {eb, 2'b11, (c == 9)}) begin
                failures++;
                $display("FAIL b2b cycle %0d got=%b exp=%b", c, {bit_out, bit_valid, busy, word_done}, {eb, 2'b11, (c == 9)});
            end
            if (c >= 3 && c <= 8) begin
                checks++;
                if (load_ready !== (c == 8)) begin
                    failures++;
                    $display("FAIL b2b_holdoff cycle %0d ready got=%b exp=%b", c, load_ready, (c == 8));
                end
            end
            if (c == 3) begin
                load_valid = 1'b1;
                load_data = w2;
            end
            if (c == 9) load_valid = 1'b0;
            cyc();
        end
        checks++;
        if ({bit_out, bit_valid, busy, word_done} !== 4'b1001) begin
            failures++;
            $display("FAIL b2b_second_done got=%b exp=1001", {bit_out, bit_valid, busy, word_done});
        end
        cyc();
    endtask

    task automatic test_stall();
        logic [10:0] exp11;
        exp11 = 11'b100_0010_0101;
        load_valid = 1'b1;
        load_data = 8'hA5;
        cyc();
        load_valid = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            checks++;
            if ({bit_out, bit_valid, busy, word_done} !== {exp11[11-c], 3'b110}) begin
                failures++;
                $display("FAIL stall cycle %0d got=%b exp=%b", c, {bit_out, bit_valid, busy, word_done}, {exp11[11-c], 3'b110});
            end
            if (c == 2) shift_en = 1'b0;
            if (c == 5) shift_en = 1'b1;
            cyc();
        end
        checks++;
        if ({bit_out, bit_valid, busy, word_done} !== 4'b1001) begin
            failures++;
            $display("FAIL stall_done got=%b exp=1001", {bit_out, bit_valid, busy, word_done});
        end
        cyc();
    endtask

    task automatic test_lsb_first();
        logic [7:0] w;
        w = 8'h01;
        lsb_load_valid = 1'b1;
        lsb_load_data = w;
        cyc();
        lsb_load_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if ({lsb_bit_out, lsb_bit_valid, lsb_busy, lsb_word_done} !== {w[c-1], 3'b110}) begin
                failures++;
                $display("FAIL lsb_first cycle %0d got=%b exp=%b", c, {lsb_bit_out, lsb_bit_valid, lsb_busy, lsb_word_done}, {w[c-1], 3'b110});
            end
            cyc();
        end
        checks++;
        if ({lsb_bit_out, lsb_bit_valid, lsb_busy, lsb_word_done} !== 4'b1001) begin
            failures++;
            $display("FAIL lsb_done got=%b exp=1001", {lsb_bit_out, lsb_bit_valid, lsb_busy, lsb_word_done});
        end
        cyc();
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] w;
        w = 8'h0F;
        load_valid = 1'b1;
        load_data = w;
        cyc();
        load_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if ({bit_out, bit_valid} !== {w[8-c], 1'b1}) begin
                failures++;
                $display("FAIL midreset_pre cycle %0d got=%b exp=%b", c, {bit_out, bit_valid}, {w[8-c], 1'b1});
            end
            if (c == 4) reset = 1'b1;
            if (c < 4) cyc();
        end
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({bit_out, bit_valid, busy, word_done, load_ready} !== 5'b10001) begin
                failures++;
                $display("FAIL midreset_idle[%0d] got=%b exp=10001", i, {bit_out, bit_valid, busy, word_done, load_ready});
            end
            cyc();
        end
        w = 8'hC3;
        load_valid = 1'b1;
        load_data = w;
        cyc();
        load_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if ({bit_out, bit_valid, word_done} !== {w[8-c], 2'b10}) begin
                failures++;
                $display("FAIL midreset_reload cycle %0d got=%b exp=%b", c, {bit_out, bit_valid, word_done}, {w[8-c], 2'b10});
            end
            cyc();
        end
        checks++;
        if ({bit_out, bit_valid, word_done} !== 3'b101) begin
            failures++;
            $display("FAIL midreset_reload_done got=%b exp=101", {bit_out, bit_valid, word_done});
        end
        cyc();
    endtask

    initial begin
        #1;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_stall();
        test_lsb_first();
        test_reset_mid_word();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
